// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
//
// Contents:
//   ps2_tx_state_e      host-to-device frame state encoding
//   DEF_*_CYCLES        default timing at a 65 MHz system clock
//   CMD_RESET/ENABLE    common device command bytes
//   odd_parity()        PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int DEF_INHIBIT_CYCLES = 6500;    // 100 us
  localparam int DEF_RTS_CYCLES     = 130;     // 2 us
  localparam int DEF_TIMEOUT_CYCLES = 975000;  // 15 ms

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer with falling-edge detect for one PS/2 line
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   line_i   raw open-collector line sample
//   sync_o   synchronized line level
//   fall_o   one-cycle pulse when the synchronized line goes 1 -> 0
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
//
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   ps2_clk_in, ps2_data_in  raw PS/2 line samples
//   ps2_clk_oe, ps2_data_oe  1 pulls the line low, 0 releases it
//   tx_data, tx_valid        command byte and send request
//   tx_ready                 high only while idle
//   tx_done, tx_err          one-cycle pulses: ACK seen / ACK missing or timeout
//   busy                     high whenever a frame is in progress
//
// Build option: PS2_TX_TIMEOUT_EN adds a watchdog that aborts a frame
// TIMEOUT_CYCLES after the clock line is released to the device.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  ps2_tx_state_e state_q, state_d;

  logic [7:0]       shift_q;
  logic             parity_q;
  logic             drive_q;     // registered data_oe while the device clocks bits
  logic [3:0]       bit_cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic             hi_q;        // both lines were high last cycle in WAIT_IDLE
  logic             done_q;
  logic             err_q;

  logic clk_s, clk_fall;
  logic data_s, data_fall_unused;
  logic tmr_hit;
  logic timeout_hit;
  logic lines_high;

  ps2_line_sync u_clk_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (ps2_clk_in),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (ps2_data_in),
    .sync_o (data_s),
    .fall_o (data_fall_unused)
  );

  assign lines_high = clk_s & data_s;
  assign tmr_hit = ((state_q == ST_INHIBIT) && (tmr_q == TMR_W'(INHIBIT_CYCLES - 1))) ||
                   ((state_q == ST_RTS)     && (tmr_q == TMR_W'(RTS_CYCLES - 1)));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_run;

  assign wd_run = (state_q == ST_DATA) || (state_q == ST_PARITY) ||
                  (state_q == ST_STOP) || (state_q == ST_ACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (wd_run) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // An ACK edge landing on the last watchdog cycle wins, so done and err
  // can never pulse together.
  assign timeout_hit = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                       !((state_q == ST_ACK) && clk_fall);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (tx_valid) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (tmr_hit) state_d = ST_RTS;
      ST_RTS:       if (tmr_hit) state_d = ST_DATA;
      ST_DATA:      if (clk_fall && (bit_cnt_q == 4'd7)) state_d = ST_PARITY;
      ST_PARITY:    if (clk_fall) state_d = ST_STOP;
      ST_STOP:      if (clk_fall) state_d = ST_ACK;
      ST_ACK:       if (clk_fall) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (lines_high && hi_q) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_WAIT_IDLE;
  end

  // Datapath: shift register, bit counter, phase timer, response pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      drive_q   <= 1'b0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      hi_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= timeout_hit;

      if (state_d != state_q) begin
        tmr_q <= '0;
      end else if ((state_q == ST_INHIBIT) || (state_q == ST_RTS)) begin
        tmr_q <= tmr_q + 1'b1;
      end

      hi_q <= (state_q == ST_WAIT_IDLE) && lines_high;

      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            shift_q  <= tx_data;
            parity_q <= odd_parity(tx_data);
          end
        end
        ST_RTS: begin
          if (tmr_hit) begin
            bit_cnt_q <= '0;
            drive_q   <= 1'b1;  // start bit keeps data low once clock is released
          end
        end
        ST_DATA: begin
          if (clk_fall) begin
            drive_q   <= ~shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: if (clk_fall) drive_q <= ~parity_q;
        ST_STOP:   if (clk_fall) drive_q <= 1'b0;
        ST_ACK: begin
          if (clk_fall) begin
            done_q <= ~data_s;
            err_q  <= data_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from the async-reset state so a reset frees the lines at once.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      ST_INHIBIT: ps2_clk_oe = 1'b1;
      ST_RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      ST_DATA, ST_PARITY, ST_STOP: ps2_data_oe = drive_q;
      default: ;
    endcase
    tx_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    tx_done  = done_q;
    tx_err   = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic [10:0] samp_r;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES(5),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
  end

  task automatic start_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    for (int i = 0; i < 500; i++) begin
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Device clocks n falling edges; samples the data line late in each low phase.
  task automatic device_run(input int n, input bit ack);
    samp_r = '0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (k == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      samp_r[k] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", tx_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send(input logic [7:0] b, input logic par, input bit ack, input string nm);
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_byte(b, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_start got no release want clk released with data low", nm); end
    checks++; if (ps2_data_in !== 1'b0) begin errors++; $display("FAIL %s_start_bit got %b want 0", nm, ps2_data_in); end
    device_run(11, ack);
    checks++; if (samp_r[7:0] !== b) begin errors++; $display("FAIL %s_data_bits got %h want %h", nm, samp_r[7:0], b); end
    checks++; if (samp_r[8] !== par) begin errors++; $display("FAIL %s_parity got %b want %b", nm, samp_r[8], par); end
    checks++; if (samp_r[9] !== 1'b1) begin errors++; $display("FAIL %s_stop got %b want 1", nm, samp_r[9]); end
    wait_idle(ok);
    checks++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL %s_idle got busy=%b want 0", nm, busy); end
    checks++; if ((done_cnt - d0) !== (ack ? 1 : 0)) begin errors++; $display("FAIL %s_done got %0d want %0d", nm, done_cnt - d0, ack ? 1 : 0); end
    checks++; if ((err_cnt - e0) !== (ack ? 0 : 1)) begin errors++; $display("FAIL %s_err got %0d want %0d", nm, err_cnt - e0, ack ? 0 : 1); end
  endtask

  task automatic test_ignore_valid;
    bit ok;
    int d0;
    d0 = done_cnt;
    start_byte(CMD_ENABLE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_start got no release want clk released"); end
    fork
      device_run(11, 1'b1);
      begin
        repeat (100) @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    checks++; if (samp_r[7:0] !== 8'hF4) begin errors++; $display("FAIL ign_data_bits got %h want f4", samp_r[7:0]); end
    checks++; if (samp_r[8] !== 1'b0) begin errors++; $display("FAIL ign_parity got %b want 0", samp_r[8]); end
    wait_idle(ok);
    checks++; if ((done_cnt - d0) !== 1) begin errors++; $display("FAIL ign_done got %0d want 1", done_cnt - d0); end
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL ign_no_refire got busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_byte(CMD_ENABLE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_start got no release want clk released"); end
    device_run(4, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_async_release got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", tx_ready); end
    checks++; if (done_cnt !== d0 || err_cnt !== e0) begin errors++; $display("FAIL rstmid_pulses got done+%0d err+%0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_silent_device;
    bit ok;
    int e0;
    e0 = err_cnt;
    start_byte(CMD_RESET, ok);
    checks++; if (!ok) begin errors++; $display("FAIL silent_start got no release want clk released"); end
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int i = 0; i < 1200; i++) begin
        @(negedge clk);
        n++;
        if (tx_err) break;
      end
      checks++; if (n !== 1000) begin errors++; $display("FAIL timeout_cycle got %0d want 1000", n); end
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL timeout_release got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
      wait_idle(ok);
      checks++; if (!ok || (err_cnt - e0) !== 1) begin errors++; $display("FAIL timeout_err got idle=%b errs=%0d want 1 1", ok, err_cnt - e0); end
    end
`else
    repeat (1500) @(negedge clk);
    checks++; if (busy !== 1'b1 || ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL silent_stuck got busy=%b data_oe=%b clk_oe=%b want 1 1 0", busy, ps2_data_oe, ps2_clk_oe); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL silent_no_err got %0d want 0", err_cnt - e0); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL silent_recover got %b want 1", tx_ready); end
`endif
  endtask

  initial begin
    test_reset;
    test_send(CMD_ENABLE, 1'b0, 1'b1, "send_f4");
    test_send(CMD_RESET, 1'b1, 1'b1, "send_ff");
    test_send(8'h3C, 1'b1, 1'b0, "nack_3c");
    test_ignore_valid;
    test_reset_midframe;
    test_silent_device;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap got %0d want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 6500, clock-low inhibit time (100 us at 65 MHz).
REQ-002 SHALL have parameter RTS_CYCLES, default 130, data-low hold time before clock release (2 us at 65 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 975000, watchdog limit (15 ms at 65 MHz).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ps2_clk_in, input, 1 bit: raw sampled PS/2 clock line.
REQ-007 SHALL have port ps2_data_in, input, 1 bit: raw sampled PS/2 data line.
REQ-008 SHALL have port ps2_clk_oe, output, 1 bit: 1 drives the clock line low, 0 releases it.
REQ-009 SHALL have port ps2_data_oe, output, 1 bit: 1 drives the data line low, 0 releases it.
REQ-010 SHALL have port tx_data, input, 8 bits: command byte to send.
REQ-011 SHALL have port tx_valid, input, 1 bit: send request.
REQ-012 SHALL have port tx_ready, output, 1 bit: high only in IDLE.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse on ACK received.
REQ-014 SHALL have port tx_err, output, 1 bit: one-cycle pulse on missing ACK or timeout.
REQ-015 SHALL have port busy, output, 1 bit: high whenever not in IDLE; the receiver gates off on it.

Function
REQ-016 SHALL capture tx_data into a shift register when tx_valid and tx_ready are both high in the same cycle.
REQ-017 SHALL ignore tx_valid while busy is high.
REQ-018 SHALL compute parity as odd parity over the 8 data bits: parity bit = ~^tx_data.
REQ-019 SHALL pass both lines through 2-FF synchronizers and act only on a detected ps2_clk falling edge (sync prev=1, cur=0).
REQ-020 SHALL use state sequence IDLE -> INHIBIT -> RTS -> DATA -> PARITY -> STOP -> ACK -> WAIT_IDLE -> IDLE.
REQ-021 INHIBIT SHALL assert ps2_clk_oe for INHIBIT_CYCLES cycles.
REQ-022 RTS SHALL assert ps2_data_oe (start bit) with the clock still held for RTS_CYCLES, then release ps2_clk_oe.
REQ-023 DATA SHALL, on each of falling edges 1..8, set ps2_data_oe = ~bit, LSB first, then enter PARITY.
REQ-024 PARITY SHALL drive ps2_data_oe = ~parity on falling edge 9.
REQ-025 STOP SHALL release ps2_data_oe on falling edge 10.
REQ-026 ACK SHALL sample synced data on falling edge 11: 0 gives a tx_done pulse, 1 gives a tx_err pulse, then enter WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL return to IDLE once both synced lines are high for 2 consecutive cycles.
REQ-028 A bit counter of 4 bits SHALL saturate nowhere; it is cleared on entry to DATA.
REQ-029 The module SHALL never drive a line high; oe=0 means released.
REQ-030 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-031 While rst=0 the block SHALL be in IDLE with outputs ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, busy=0, and shift register=0.
REQ-032 Reset asserted mid-frame SHALL release both lines immediately (asynchronously), with no err/done pulse.

Configuration
REQ-033 Macro PS2_TX_TIMEOUT_EN: when defined, a watchdog counts from leaving RTS; reaching TIMEOUT_CYCLES before ACK completes releases both lines, pulses tx_err, and goes to WAIT_IDLE.
REQ-034 Without PS2_TX_TIMEOUT_EN no watchdog SHALL exist, and a silent device leaves the block in DATA indefinitely (recoverable only by reset).

Structure
REQ-035 Package ps2_pkg SHALL hold the state enum type, the default cycle constants, and command constants CMD_RESET=8'hFF and CMD_ENABLE=8'hF4.
REQ-036 Sub-module ps2_line_sync SHALL implement the 2-FF synchronizer and falling-edge detect, instantiated once per line.

Verification
REQ-037 Send 8'hF4 with a device model ACKing -> bits 0,0,1,0,1,1,1,1, parity 0, tx_done pulses once, busy returns to 0.
REQ-038 Send 8'hFF -> parity bit 1 on edge 9, tx_done pulses once.
REQ-039 Device leaves data high on edge 11 -> tx_err pulses once, no tx_done.
REQ-040 Enable PS2_TX_TIMEOUT_EN with TIMEOUT_CYCLES=1000 and a device that never clocks -> tx_err pulses at cycle 1000 after RTS, both oe=0.
REQ-041 Drive rst low after edge 4 -> both oe=0 in the same cycle, tx_ready=1 after release.
REQ-042 Pulse tx_valid with 8'h00 during a frame -> ignored, current byte completes unchanged.
